// File: rtl/countdown_counter_4bits.sv
// countdown_counter_4bits: loadable down-counter with one-shot / auto-reload modes.
// Q counts a loaded value down to 0. In one-shot mode it stops there (EXPIRED).
// In auto-reload mode it restarts from the captured reload value.
// done is a registered one-cycle pulse when Q passes through 0.
// rbo is a combinational borrow output for cascading counters.
module countdown_counter_4bits #(
  parameter int          WIDTH      = 4,
  parameter int unsigned RELOAD_RST = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             rbo
);

  localparam logic [1:0] MODO_ONESHOT = 2'b00;
  localparam logic [1:0] MODO_LOAD    = 2'b01;
  localparam logic [1:0] MODO_AUTO    = 2'b10;
  localparam logic [1:0] MODO_HOLD    = 2'b11;

  localparam logic [WIDTH-1:0] RELOAD_INIT = WIDTH'(RELOAD_RST);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic             done_nxt;
  logic             q_zero;
  logic             counting_mode;

  assign q_zero        = (Q == '0);
  assign counting_mode = (modo == MODO_ONESHOT) || (modo == MODO_AUTO);

  // State, count, reload value and done pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      Q      <= '0;
      reload <= RELOAD_INIT;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      Q      <= q_nxt;
      reload <= reload_nxt;
      done   <= done_nxt;
    end
  end

  // Next-state logic.
  // When enb is low, everything holds and done drops.
  // A decrement is never applied at Q==0, so the counter cannot wrap to all-ones.
  always_comb begin
    state_nxt  = state;
    q_nxt      = Q;
    reload_nxt = reload;
    done_nxt   = 1'b0;
    if (enb) begin
      case (modo)
        MODO_LOAD: begin
          q_nxt      = data;
          reload_nxt = data;
          state_nxt  = RUN;
        end
        MODO_ONESHOT: begin
          if (state == RUN) begin
            if (!q_zero) begin
              q_nxt = Q - 1'b1;
            end else begin
              done_nxt  = 1'b1;
              state_nxt = EXPIRED;
            end
          end
        end
        MODO_AUTO: begin
          if (state == RUN) begin
            if (!q_zero) begin
              q_nxt = Q - 1'b1;
            end else begin
              // Terminal count: reload and pulse done.
              // If reload is 0, this repeats every enabled cycle.
              q_nxt    = reload;
              done_nxt = 1'b1;
            end
          end else begin
            // Start from IDLE/EXPIRED: one cycle to present the reload value
            q_nxt     = reload;
            state_nxt = RUN;
          end
        end
        MODO_HOLD: begin
          // Hold: Q, state and reload keep their values; done stays at its default 0
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign rbo  = enb && busy && q_zero && counting_mode;

endmodule
